// File: rtl/inst_prefetch_buffer_if.sv
// Signal bundle between the prefetch buffer, instruction memory, IF/ID and the redirect source.
// master = prefetch buffer side, slave = memory / pipeline side.
interface inst_prefetch_buffer_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, out_valid, out_pc, out_instr,
        input  mem_ack, mem_rdata, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_pc, out_instr,
        output mem_ack, mem_rdata, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue: one outstanding fetch, DEPTH-entry {pc, instr} FIFO, redirect flush.
// Optional PREFETCH_ISSUE_ON_ACK_EN issues the next fetch in the same cycle as an accepted ack.
module inst_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic                    clk,
    input logic                    rst,
    inst_prefetch_buffer_if.master pf
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        ent_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q;
    logic [63:0]   fetch_pc_q, mem_addr_q, out_pc_q;
    logic [31:0]   out_instr_q;
    logic          mem_req_q, out_valid_q;
    logic          redir, push, pop;
    logic [63:0]   redir_pc;
    entry_t        head_ent;

    assign redir    = pf.redirect_valid;
    assign redir_pc = pf.redirect_pc & ~64'h3;
    // A redirect kills both the arriving response and the IF/ID handoff of this cycle.
    assign push     = (state_q == WAIT) && pf.mem_ack && !redir;
    assign pop      = out_valid_q && pf.out_ready && !redir;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (redir) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // The entry landing this cycle is not in storage yet; forward it when it becomes head.
        head_ent = ent_q[head_d];
        if (push && (head_d == tail_q))
            head_ent = '{pc: mem_addr_q, instr: pf.mem_rdata};
    end

    always_ff @(posedge clk) begin
        if (push) ent_q[tail_q] <= '{pc: mem_addr_q, instr: pf.mem_rdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
            if (count_d != '0) begin
                out_pc_q    <= head_ent.pc;
                out_instr_q <= head_ent.instr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redir) begin
                        fetch_pc_q <= redir_pc;
                    end else if (count_q < DEPTH_C) begin
                        state_q    <= WAIT;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 64'd4;
                    end
                end
                WAIT: begin
                    if (redir) begin
                        fetch_pc_q <= redir_pc;
                        mem_req_q  <= 1'b0;
                        state_q    <= pf.mem_ack ? IDLE : DROP;
                    end else if (pf.mem_ack) begin
`ifdef PREFETCH_ISSUE_ON_ACK_EN
                        if (count_d < DEPTH_C) begin
                            mem_addr_q <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + 64'd4;
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end
`else
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
`endif
                    end
                end
                DROP: begin
                    // The abandoned response still owes us an ack; swallow it before refetching.
                    if (redir)      fetch_pc_q <= redir_pc;
                    if (pf.mem_ack) state_q    <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign pf.mem_req   = mem_req_q;
    assign pf.mem_addr  = mem_addr_q;
    assign pf.out_valid = out_valid_q;
    assign pf.out_pc    = out_pc_q;
    assign pf.out_instr = out_instr_q;
endmodule

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch byte address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port mem_addr  output  64  byte address of requested word.
REQ-007 SHALL have port mem_ack  input  1  one-cycle pulse; mem_rdata valid.
REQ-008 SHALL have port mem_rdata  input  32  returned instruction.
REQ-009 SHALL have port out_valid  output  1  head entry available to IF/ID.
REQ-010 SHALL have port out_pc  output  64  PC of head entry.
REQ-011 SHALL have port out_instr  output  32  instruction of head entry.
REQ-012 SHALL have port out_ready  input  1  IF/ID accepts head (low during load-use stall).
REQ-013 SHALL have port redirect_valid  input  1  taken branch/flush, one-cycle pulse.
REQ-014 SHALL have port redirect_pc  input  64  new fetch byte address.

Function
REQ-015 SHALL hold a circular queue of DEPTH {pc, instr} entries with head/tail pointers and count 0..DEPTH.
REQ-016 SHALL keep fetch_pc; each issued request uses mem_addr = fetch_pc, then fetch_pc += 4 (64-bit wrap).
REQ-017 SHALL allow at most one outstanding request; FSM states IDLE, WAIT, DROP.
REQ-018 IDLE->WAIT: mem_req asserted when count + 0 < DEPTH and no redirect this cycle.
REQ-019 In WAIT, mem_req and mem_addr SHALL stay constant until mem_ack; on mem_ack, push {addr, mem_rdata} and go IDLE.
REQ-020 Requests SHALL only issue when a free slot is reserved, so a push never overflows.
REQ-021 Pop SHALL occur when out_valid && out_ready; push and pop in same cycle SHALL leave count unchanged.
REQ-022 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL be the head entry, registered.
REQ-023 Redirect SHALL empty the queue next cycle (count=0), set fetch_pc = redirect_pc, and override any same-cycle pop/push.
REQ-024 Redirect during WAIT (without same-cycle mem_ack) SHALL go to DROP; mem_req deasserts; the later mem_ack is discarded, then IDLE.
REQ-025 Redirect coincident with mem_ack SHALL discard that response and go IDLE.
REQ-026 Redirect in DROP SHALL update fetch_pc and remain in DROP.
REQ-027 redirect_pc[1:0] SHALL be ignored (forced to 00).
REQ-028 Steady state with out_ready=1 and single-cycle mem_ack SHALL sustain one instruction per two cycles (IDLE/WAIT alternate) unless bypass is enabled.

Reset
REQ-029 On rst low, asynchronously: fetch_pc=RESET_PC, count=0, pointers=0, state IDLE, mem_req=0, mem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
REQ-030 Reset mid-WAIT SHALL abandon the request; a mem_ack arriving after release in IDLE SHALL be ignored.

Configuration
REQ-031 Macro PREFETCH_ISSUE_ON_ACK_EN: when defined, on mem_ack with a free slot remaining and no redirect, the next request issues in the same cycle (WAIT->WAIT), giving one instruction per cycle with single-cycle memory.
REQ-032 Without PREFETCH_ISSUE_ON_ACK_EN, every mem_ack SHALL pass through IDLE for one cycle before the next mem_req.

Verification
REQ-033 Reset release, mem_ack 1 cycle after each req, out_ready=1 -> out_pc sequence 0,4,8,C with matching instr.
REQ-034 out_ready=0 for 10 cycles -> count saturates at 4, mem_req low, no entry lost; releasing yields PCs 0..C in order.
REQ-035 redirect_valid with redirect_pc=0x40 while WAIT on 0x10 -> DROP, ack for 0x10 discarded, next out_pc=0x40.
REQ-036 redirect coincident with mem_ack and pop, count=2 -> count=0 next cycle, fetch_pc=redirect_pc.
REQ-037 rst low while WAIT, stray mem_ack after release -> ignored, first out_pc=RESET_PC.
REQ-038 With PREFETCH_ISSUE_ON_ACK_EN, single-cycle memory -> out_valid high every cycle after fill, PCs consecutive by 4.
